// File: rtl/ride_pkg.sv
// Shared types and constants for the ride dispatch controller: safety FSM
// states, dispatch phases, abort cause codes and small helper functions.
package ride_pkg;

    typedef enum logic [1:0] {
        SAFE_NORMAL   = 2'd0,
        SAFE_WARNING  = 2'd1,
        SAFE_FAULT    = 2'd2,
        SAFE_SHUTDOWN = 2'd3
    } safety_e;

    // Encoding 3'd7 is unused and recovers to PH_ABORT.
    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_LOCK   = 3'd1,
        PH_CHECK  = 3'd2,
        PH_RUN    = 3'd3,
        PH_BRAKE  = 3'd4,
        PH_UNLOAD = 3'd5,
        PH_ABORT  = 3'd6
    } phase_e;

    localparam logic [2:0] ABRT_NONE     = 3'd0;
    localparam logic [2:0] ABRT_LOCK_TO  = 3'd1;
    localparam logic [2:0] ABRT_CHECK_TO = 3'd2;
    localparam logic [2:0] ABRT_FAULT    = 3'd3;
    localparam logic [2:0] ABRT_ESTOP    = 3'd4;
    localparam logic [2:0] ABRT_SHUTDOWN = 3'd5;

    // Resolve simultaneous abort causes: estop > shutdown > fault > lock > check.
    function automatic logic [2:0] abort_cause(input logic estop_c,
                                               input logic shutdown_c,
                                               input logic fault_c,
                                               input logic lock_c,
                                               input logic check_c);
        if (estop_c)         return ABRT_ESTOP;
        else if (shutdown_c) return ABRT_SHUTDOWN;
        else if (fault_c)    return ABRT_FAULT;
        else if (lock_c)     return ABRT_LOCK_TO;
        else if (check_c)    return ABRT_CHECK_TO;
        else                 return ABRT_NONE;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ride_phase_timer.sv
// Loadable down-counter for phase durations. Counts down to zero and holds;
// done is high while the count is zero.
module ride_phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    // Reload on request, otherwise decrement until zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/ride_dispatch_ctrl.sv
// Ride dispatch controller: sequences IDLE -> LOCK -> CHECK -> RUN -> BRAKE
// -> UNLOAD with abort handling. All outputs are registered.
// Optional feature: define RIDE_CYCLE_COUNT_EN to build the saturating
// completed-ride counter; otherwise cycle_count is tied to zero.
module ride_dispatch_ctrl
    import ride_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT  = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned RUN_CYCLES    = 64,
    parameter int unsigned BRAKE_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  safety_state,
    input  logic        start_req,
    input  logic        station_clear,
    input  logic        restraints_locked,
    input  logic        estop,
    input  logic        ack_clear,
    output logic        start_ack,
    output logic [2:0]  phase,
    output logic        motor_en,
    output logic        brake_cmd,
    output logic        lock_cmd,
    output logic        gates_open,
    output logic [2:0]  abort_code,
    output logic [15:0] cycle_count
);

    localparam int unsigned CHECK_TIMEOUT = 4 * SETTLE_CYCLES;
    localparam int unsigned T_MAX = max_u(max_u(LOCK_TIMEOUT, CHECK_TIMEOUT),
                                          max_u(RUN_CYCLES, BRAKE_CYCLES));
    localparam int unsigned TW = $clog2(T_MAX + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    safety_e         safety;
    phase_e          phase_q, phase_d;
    logic [2:0]      abort_q, abort_d, cause;
    logic [SW-1:0]   settle_q, settle_d;
    logic            settle_hit;
    logic            start_ack_q, start_ack_d;
    logic            motor_q, motor_d, brake_q, brake_d;
    logic            lock_q, lock_d, gates_q, gates_d;
    logic            tmr_load, tmr_done;
    logic [TW-1:0]   tmr_val;

    assign safety = safety_e'(safety_state);

    ride_phase_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next phase, abort cause latching and settle counting.
    always_comb begin
        phase_d     = phase_q;
        abort_d     = abort_q;
        start_ack_d = 1'b0;
        settle_d    = '0;
        settle_hit  = 1'b0;
        cause       = ABRT_NONE;
        case (phase_q)
            PH_IDLE: begin
                if (start_req && station_clear && safety == SAFE_NORMAL && !estop) begin
                    start_ack_d = 1'b1;
                    phase_d     = PH_LOCK;
                end
            end
            PH_LOCK: begin
                cause = abort_cause(estop, 1'b0, 1'b0, !restraints_locked && tmr_done, 1'b0);
                if (restraints_locked) phase_d = PH_CHECK;
            end
            PH_CHECK: begin
                if (safety == SAFE_NORMAL) begin
                    settle_d   = settle_q + SW'(1);
                    settle_hit = (settle_q == SW'(SETTLE_CYCLES - 1));
                end
                cause = abort_cause(estop, 1'b0, 1'b0, !restraints_locked, tmr_done && !settle_hit);
                if (settle_hit) phase_d = PH_RUN;
            end
            PH_RUN: begin
                cause = abort_cause(estop, safety == SAFE_SHUTDOWN, safety == SAFE_FAULT, 1'b0, 1'b0);
                if (tmr_done) phase_d = PH_BRAKE;
            end
            PH_BRAKE: begin
                cause = abort_cause(estop, 1'b0, 1'b0, 1'b0, 1'b0);
                if (tmr_done) phase_d = PH_UNLOAD;
            end
            PH_UNLOAD: begin
                cause = abort_cause(estop, 1'b0, 1'b0, 1'b0, 1'b0);
                if (!restraints_locked) phase_d = PH_IDLE;
            end
            PH_ABORT: begin
                if (ack_clear && !estop && (safety == SAFE_NORMAL || safety == SAFE_WARNING)) begin
                    phase_d = PH_UNLOAD;
                end
            end
            default: begin
                phase_d = PH_ABORT;
                abort_d = ABRT_ESTOP;
            end
        endcase
        // cause stays NONE inside ABORT, so a latched code is never overwritten.
        if (cause != ABRT_NONE) begin
            phase_d = PH_ABORT;
            abort_d = cause;
        end
        if (phase_d == PH_IDLE && phase_q != PH_IDLE) abort_d = ABRT_NONE;
    end

    // Phase timer reload on every phase change; loaded with N-1 so expiry
    // at zero gives a phase length of exactly N cycles.
    always_comb begin
        tmr_load = (phase_d != phase_q);
        case (phase_d)
            PH_LOCK:  tmr_val = TW'(LOCK_TIMEOUT - 1);
            PH_CHECK: tmr_val = TW'(CHECK_TIMEOUT - 1);
            PH_RUN:   tmr_val = TW'(RUN_CYCLES - 1);
            PH_BRAKE: tmr_val = TW'(BRAKE_CYCLES - 1);
            default:  tmr_val = '0;
        endcase
    end

    // Actuator commands decoded from the upcoming phase, registered below.
    always_comb begin
        motor_d = (phase_d == PH_RUN);
        brake_d = (phase_d inside {PH_IDLE, PH_BRAKE, PH_UNLOAD, PH_ABORT});
        lock_d  = (phase_d inside {PH_LOCK, PH_CHECK, PH_RUN, PH_BRAKE, PH_ABORT});
        gates_d = (phase_d inside {PH_IDLE, PH_UNLOAD});
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q     <= PH_IDLE;
            abort_q     <= ABRT_NONE;
            settle_q    <= '0;
            start_ack_q <= 1'b0;
            motor_q     <= 1'b0;
            brake_q     <= 1'b1;
            lock_q      <= 1'b0;
            gates_q     <= 1'b1;
        end else begin
            phase_q     <= phase_d;
            abort_q     <= abort_d;
            settle_q    <= settle_d;
            start_ack_q <= start_ack_d;
            motor_q     <= motor_d;
            brake_q     <= brake_d;
            lock_q      <= lock_d;
            gates_q     <= gates_d;
        end
    end

    assign phase      = phase_q;
    assign abort_code = abort_q;
    assign start_ack  = start_ack_q;
    assign motor_en   = motor_q;
    assign brake_cmd  = brake_q;
    assign lock_cmd   = lock_q;
    assign gates_open = gates_q;

`ifdef RIDE_CYCLE_COUNT_EN
    logic [15:0] count_q, count_d;
    logic        from_brake_q, from_brake_d;

    // Remember whether UNLOAD was entered from BRAKE; count saturating rides.
    always_comb begin
        from_brake_d = (phase_q == PH_UNLOAD) ? from_brake_q : (phase_q == PH_BRAKE);
        count_d      = count_q;
        if (phase_q == PH_UNLOAD && phase_d == PH_IDLE && from_brake_q && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    // Ride counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q      <= '0;
            from_brake_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            from_brake_q <= from_brake_d;
        end
    end

    assign cycle_count = count_q;
`else
    assign cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ride_dispatch_ctrl.sv
// Scoreboard bench for ride_dispatch_ctrl with default parameters. Stimulus
// pushes the expected phase transitions (with dwell time in the previous
// phase); a monitor pops and compares whenever the phase changes, start_ack
// pulses or reset is released.
module tb_ride_dispatch_ctrl;

    localparam int P_IDLE = 0, P_LOCK = 1, P_CHECK = 2, P_RUN = 3;
    localparam int P_BRAKE = 4, P_UNLOAD = 5, P_ABORT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  safety_state = 2'd0;
    logic        start_req = 1'b0, station_clear = 1'b0, restraints_locked = 1'b0;
    logic        estop = 1'b0, ack_clear = 1'b0;
    logic        start_ack, motor_en, brake_cmd, lock_cmd, gates_open;
    logic [2:0]  phase, abort_code;
    logic [15:0] cycle_count;

    ride_dispatch_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .safety_state      (safety_state),
        .start_req         (start_req),
        .station_clear     (station_clear),
        .restraints_locked (restraints_locked),
        .estop             (estop),
        .ack_clear         (ack_clear),
        .start_ack         (start_ack),
        .phase             (phase),
        .motor_en          (motor_en),
        .brake_cmd         (brake_cmd),
        .lock_cmd          (lock_cmd),
        .gates_open        (gates_open),
        .abort_code        (abort_code),
        .cycle_count       (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int ack;
        int code;
        int cnt;
        int dwell;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int ph, input int ack, input int code, input int dwell);
        exp_t e;
        e.ph = ph; e.ack = ack; e.code = code; e.cnt = exp_count; e.dwell = dwell;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // {motor_en, brake_cmd, lock_cmd, gates_open} per phase
    function automatic logic [3:0] act_exp(input logic [2:0] ph);
        case (ph)
            3'd0:       return 4'b0101;
            3'd1, 3'd2: return 4'b0010;
            3'd3:       return 4'b1010;
            3'd4, 3'd6: return 4'b0110;
            3'd5:       return 4'b0101;
            default:    return 4'b0000;
        endcase
    endfunction

    initial begin : monitor
        logic [2:0] last_phase;
        logic       prev_rst;
        logic       started;
        int         ncyc, last_ev;
        exp_t       e;
        last_phase = 3'd0; prev_rst = 1'b0; started = 1'b0; ncyc = 0; last_ev = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (started) check("actuators", 32'({motor_en, brake_cmd, lock_cmd, gates_open}), 32'(act_exp(phase)));
            if (phase !== last_phase || start_ack !== 1'b0 || (!prev_rst && rst_n)) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: phase=%0d start_ack=%0b with empty scoreboard at %0t",
                             phase, start_ack, $time);
                end else begin
                    e = sb.pop_front();
                    check("phase", 32'(phase), e.ph);
                    check("start_ack", 32'(start_ack), e.ack);
                    check("abort_code", 32'(abort_code), e.code);
                    check("cycle_count", 32'(cycle_count), e.cnt);
                    if (e.dwell >= 0) check("dwell", ncyc - last_ev, e.dwell);
                end
                last_ev = ncyc;
                started = 1'b1;
            end
            last_phase = phase;
            prev_rst   = rst_n;
        end
    end

    // Request dispatch from IDLE; returns 2 time units after the LOCK entry edge.
    task automatic start_ride();
        station_clear = 1'b1;
        start_req     = 1'b1;
        expect_ev(P_LOCK, 1, 0, -1);
        tick(1);
        start_req = 1'b0;
    endtask

    // Dispatch with restraints locked after one cycle; returns just inside RUN.
    task automatic go_run();
        start_ride();
        restraints_locked = 1'b1;
        expect_ev(P_CHECK, 0, 0, 1);
        expect_ev(P_RUN, 0, 0, 4);
        tick(5);
    endtask

    task automatic nominal();
        start_ride();
        tick(2);
        restraints_locked = 1'b1;
        expect_ev(P_CHECK, 0, 0, 3);
        expect_ev(P_RUN, 0, 0, 4);
        expect_ev(P_BRAKE, 0, 0, 64);
        expect_ev(P_UNLOAD, 0, 0, 8);
`ifdef RIDE_CYCLE_COUNT_EN
        exp_count = exp_count + 1;
`endif
        expect_ev(P_IDLE, 0, 0, 3);
        tick(1);
        tick(76);
        tick(2);
        restraints_locked = 1'b0;
        tick(1);
    endtask

    // Acknowledge an abort and leave through UNLOAD back to IDLE.
    task automatic clear_abort(input int code, input int abort_dwell);
        safety_state = 2'd0;
        ack_clear    = 1'b1;
        expect_ev(P_UNLOAD, 0, code, abort_dwell);
        expect_ev(P_IDLE, 0, 0, 1);
        tick(1);
        ack_clear         = 1'b0;
        restraints_locked = 1'b0;
        tick(1);
    endtask

    initial begin : stimulus
        expect_ev(P_IDLE, 0, 0, -1);
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Nominal ride
        nominal();

        // IDLE rejects dispatch without clear platform, with estop, with WARNING
        start_req = 1'b1; station_clear = 1'b0;
        tick(2);
        station_clear = 1'b1; estop = 1'b1;
        tick(2);
        estop = 1'b0; safety_state = 2'd1;
        tick(2);
        safety_state = 2'd0; start_req = 1'b0;
        tick(1);

        // Lock timeout
        start_ride();
        expect_ev(P_ABORT, 0, 1, 16);
        tick(16);
        clear_abort(1, 1);

        // Fault at RUN cycle 10; estop inside ABORT must not overwrite code 3
        go_run();
        tick(9);
        safety_state = 2'd2;
        expect_ev(P_ABORT, 0, 3, 10);
        tick(1);
        safety_state = 2'd0; estop = 1'b1;
        tick(1);
        estop = 1'b0;
        clear_abort(3, 2);

        // Estop and SHUTDOWN together in RUN; ack ignored while SHUTDOWN
        go_run();
        tick(4);
        estop = 1'b1; safety_state = 2'd3;
        expect_ev(P_ABORT, 0, 4, 5);
        tick(1);
        estop = 1'b0; ack_clear = 1'b1;
        tick(3);
        clear_abort(4, 4);

        // Safety toggling 0/1 every 2 cycles in CHECK never settles
        start_ride();
        restraints_locked = 1'b1;
        expect_ev(P_CHECK, 0, 0, 1);
        expect_ev(P_ABORT, 0, 2, 16);
        tick(1);
        for (int i = 0; i < 16; i++) begin
            safety_state = ((i / 2) % 2 == 1) ? 2'd1 : 2'd0;
            tick(1);
        end
        clear_abort(2, 1);

        // Estop coinciding with lock timeout latches estop
        start_ride();
        tick(15);
        estop = 1'b1;
        expect_ev(P_ABORT, 0, 4, 16);
        tick(1);
        estop = 1'b0;
        clear_abort(4, 1);

        nominal();

        // Reset pulsed mid-RUN goes straight to IDLE
        go_run();
        tick(5);
        rst_n = 1'b0;
        exp_count = 0;
        expect_ev(P_IDLE, 0, 0, 6);
        tick(1);
        rst_n = 1'b1;
        restraints_locked = 1'b0;
        tick(2);

        nominal();

        tick(5);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ride_dispatch_ctrl.md
RIDE_DISPATCH_CTRL -- requirements
Module: ride_dispatch_ctrl

Interface
REQ-001 Parameters SHALL be: LOCK_TIMEOUT, default 16, max cycles to obtain restraint lock; SETTLE_CYCLES, default 4, consecutive NORMAL safety cycles before launch; RUN_CYCLES, default 64, motor-on duration; BRAKE_CYCLES, default 8, brake duration before unload.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 safety_state  in  2  safety FSM state: 0 NORMAL, 1 WARNING, 2 FAULT, 3 SHUTDOWN.
REQ-005 start_req  in  1  operator dispatch request, level.
REQ-006 station_clear  in  1  platform sensors report no guest in the ride envelope.
REQ-007 restraints_locked  in  1  all restraint-locked feedback.
REQ-008 estop  in  1  emergency stop, level.
REQ-009 ack_clear  in  1  operator clear after abort, level.
REQ-010 start_ack  out  1  one-cycle pulse when a dispatch is accepted.
REQ-011 phase  out  3  current phase: 0 IDLE, 1 LOCK, 2 CHECK, 3 RUN, 4 BRAKE, 5 UNLOAD, 6 ABORT.
REQ-012 motor_en, brake_cmd, lock_cmd, gates_open  out  1 each  actuator commands.
REQ-013 abort_code  out  3  latched abort cause: 0 none, 1 lock timeout, 2 check timeout, 3 safety fault, 4 estop, 5 safety shutdown.
REQ-014 cycle_count  out  16  completed ride cycles; present only with the macro in REQ-032.

Function
REQ-015 All outputs SHALL be registered, and each SHALL be a function of the registered phase or a latched register only.
REQ-016 IDLE: gates_open=1, brake_cmd=1; with start_req=1, station_clear=1, safety_state=0 and estop=0, start_ack SHALL pulse 1 and the next phase SHALL be LOCK. Otherwise the block stays in IDLE and start_ack stays 0.
REQ-017 LOCK: lock_cmd=1 and the phase timer loads LOCK_TIMEOUT. restraints_locked=1 -> CHECK. On timer expiry -> ABORT with code 1.
REQ-018 CHECK: lock_cmd=1. The settle counter SHALL count consecutive cycles with safety_state=0 and clear on any other value. Reaching SETTLE_CYCLES -> RUN. The check timeout is 4*SETTLE_CYCLES cycles; expiry -> ABORT with code 2. restraints_locked=0 -> ABORT with code 1.
REQ-019 RUN: motor_en=1, lock_cmd=1 for exactly RUN_CYCLES cycles, then BRAKE. WARNING is tolerated. FAULT -> ABORT code 3. SHUTDOWN -> ABORT code 5.
REQ-020 BRAKE: brake_cmd=1, lock_cmd=1 for BRAKE_CYCLES cycles, then UNLOAD.
REQ-021 UNLOAD: brake_cmd=1, gates_open=1, lock_cmd=0. restraints_locked=0 -> IDLE, and cycle_count increments only on this transition when it is reached from BRAKE.
REQ-022 ABORT: motor_en=0, brake_cmd=1, lock_cmd=1, and abort_code holds.
REQ-023 Exit from ABORT SHALL require ack_clear=1, estop=0 and safety_state<=1; the block then goes to UNLOAD and abort_code clears to 0 on entry to IDLE.
REQ-024 While safety_state=3, ack_clear SHALL be ignored and the block stays in ABORT.
REQ-025 estop=1 in any non-IDLE, non-ABORT phase SHALL force ABORT on the next edge.
REQ-026 Simultaneous abort causes SHALL latch the code by priority: 4 > 5 > 3 > 1 > 2. A new cause arriving in ABORT SHALL NOT overwrite the latched code.
REQ-027 Timer arithmetic: a single down-counter sized to the widest parameter, reloaded on every phase entry. Expiry is at count 0, so a phase lasts exactly the parameter value in cycles.
REQ-028 cycle_count SHALL saturate at 16'hFFFF with no wrap-around.
REQ-029 Unused phase encoding 7 SHALL recover to ABORT with code 4.

Reset
REQ-030 With rst_n=0 at a clock edge: phase=IDLE, start_ack=0, motor_en=0, brake_cmd=1, lock_cmd=0, gates_open=1, abort_code=0, cycle_count=0, timers=0.
REQ-031 Reset asserted mid-RUN SHALL take effect at the next edge with no intermediate phase.

Configuration
REQ-032 With RIDE_CYCLE_COUNT_EN defined, the cycle_count register and port exist per REQ-021 and REQ-028. Without it, the port SHALL still exist, tied to 16'h0000, with no counter flops.

Structure
REQ-033 A shared package ride_pkg SHALL hold the safety state enum, the phase enum and the abort code constants. The safety FSM SHALL use the same enum.
REQ-034 One sub-module, ride_phase_timer, SHALL implement the loadable down-counter with a done flag. The FSM stays in ride_dispatch_ctrl.

Verification
REQ-035 Nominal cycle, default parameters: start_req with safety 0 and locked after 3 cycles -> start_ack pulse, RUN lasting 64 cycles, BRAKE 8, UNLOAD, IDLE, cycle_count=1.
REQ-036 restraints_locked held 0 -> ABORT after 16 cycles in LOCK, abort_code=1, motor_en stays 0.
REQ-037 safety_state=2 at RUN cycle 10 -> next edge ABORT, code 3. ack_clear with safety 0 -> UNLOAD -> IDLE, code 0, count unchanged.
REQ-038 estop and safety_state=3 in the same RUN cycle -> code 4. ack_clear ignored while safety=3. Release both, then ack -> exit.
REQ-039 safety_state toggles 0/1 every 2 cycles in CHECK -> no RUN, ABORT code 2 after 16 cycles.
REQ-040 Reset pulsed mid-RUN -> next edge phase 0, motor_en 0, all outputs at REQ-030 values.
